// File: rtl/bus_ram_bridge.sv
// uart2bus internal-bus terminator mapping the bus address space onto NUM_BANKS RAM banks,
// with registered grant/RAM strobes, a latency-matched read return and a saturating error count.
module bus_ram_bridge #(
    parameter int unsigned BUS_AW     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BANK_AW    = 10,
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [DATA_W-1:0] OOR_DATA = 8'hFF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [BUS_AW-1:0]             int_address,
    input  logic [DATA_W-1:0]             int_wr_data,
    input  logic                          int_write,
    input  logic                          int_read,
    input  logic                          int_req,
    output logic                          int_gnt,
    output logic [DATA_W-1:0]             int_rd_data,
    output logic                          int_rd_valid,
    output logic [BANK_AW-1:0]            ram_addr,
    output logic [DATA_W-1:0]             ram_wr_data,
    output logic [NUM_BANKS-1:0]          ram_we,
    output logic [NUM_BANKS-1:0]          ram_en,
    input  logic [NUM_BANKS*DATA_W-1:0]   ram_rd_data,
    output logic [15:0]                   err_count
);

    localparam int unsigned BANK_W = $clog2(NUM_BANKS);
    localparam int unsigned BIDX_W = (BANK_W > 0) ? BANK_W : 1;
    localparam int unsigned DEC_W  = BANK_AW + BANK_W;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIDX_W-1:0]      bank_q, bank_d;
    logic                   oor_q, oor_d;
    logic                   gnt_q;
    logic [NUM_BANKS-1:0]   we_q, we_d;
    logic [NUM_BANKS-1:0]   en_q, en_d;
    logic [BANK_AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]      wd_q, wd_d;
    logic                   valid_q, valid_d;
    logic [DATA_W-1:0]      rd_hold_q;
    logic [15:0]            err_q;
    logic                   err_inc;

    logic [BIDX_W-1:0]      bank;
    logic                   in_range;
    logic [NUM_BANKS-1:0]   bank_oh;
    logic [DATA_W-1:0]      sel_data;
    logic [DATA_W-1:0]      rd_out;

    if (BANK_W > 0) begin : g_bank
        assign bank = int_address[BANK_AW +: BANK_W];
    end else begin : g_one_bank
        assign bank = '0;
    end

    // NUM_BANKS is a power of two, so "address < NUM_BANKS << BANK_AW" is "upper bits zero".
    if (DEC_W < BUS_AW) begin : g_upper
        assign in_range = ~|int_address[BUS_AW-1:DEC_W];
    end else begin : g_full
        assign in_range = 1'b1;
    end

    always_comb begin
        bank_oh       = '0;
        bank_oh[bank] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        oor_d   = oor_q;
        we_d    = '0;
        en_d    = '0;
        addr_d  = addr_q;
        wd_d    = wd_q;
        valid_d = 1'b0;
        err_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_q && int_write) begin
                    err_inc = int_read || !in_range;
                    if (in_range) begin
                        we_d   = bank_oh;
                        addr_d = int_address[BANK_AW-1:0];
                        wd_d   = int_wr_data;
                    end
                end else if (gnt_q && int_read) begin
                    err_inc = !in_range;
                    if (in_range) begin
                        en_d   = bank_oh;
                        addr_d = int_address[BANK_AW-1:0];
                    end
                    bank_d  = bank;
                    oor_d   = !in_range;
                    cnt_d   = CNT_W'(1);
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                err_inc = gnt_q && (int_write || int_read);
                if (cnt_q == CNT_W'(RD_LATENCY)) begin
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_BANKS; k++) begin
            if (bank_q == BIDX_W'(k)) sel_data = ram_rd_data[k*DATA_W +: DATA_W];
        end
    end

    // The bank slice is forwarded in the valid cycle itself so RAM data lands RD_LATENCY
    // cycles after ram_en; the hold register keeps it until the next read completes.
    assign rd_out = valid_q ? (oor_q ? OOR_DATA : sel_data) : rd_hold_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bank_q    <= '0;
            oor_q     <= 1'b0;
            gnt_q     <= 1'b0;
            we_q      <= '0;
            en_q      <= '0;
            addr_q    <= '0;
            wd_q      <= '0;
            valid_q   <= 1'b0;
            rd_hold_q <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bank_q    <= bank_d;
            oor_q     <= oor_d;
            gnt_q     <= int_req;
            we_q      <= we_d;
            en_q      <= en_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            valid_q   <= valid_d;
            rd_hold_q <= rd_out;
            if (err_inc && (err_q != '1)) err_q <= err_q + 1'b1;
        end
    end

    assign int_gnt      = gnt_q;
    assign int_rd_data  = rd_out;
    assign int_rd_valid = valid_q;
    assign ram_addr     = addr_q;
    assign ram_wr_data  = wd_q;
    assign ram_we       = we_q;
    assign ram_en       = en_q;
    assign err_count    = err_q;

endmodule

// File: doc/bus_ram_bridge.md
Name: bus_ram_bridge

Overview:
Parametrised successor to the single-bank UART-bus-to-SRAM bridge. Terminates the uart2bus internal bus (req/gnt, write/read strobes) and maps the bus address space onto NUM_BANKS independent RAM banks. Each bank is a true or simple dual-port RAM whose other port feeds display or debug logic. Adds bank decode, a registered read path with configurable RAM latency and a valid strobe, out-of-range handling, and a saturating error counter.

Parameters:
BUS_AW, 16, bus address width.
DATA_W, 8, data width on the bus and RAM.
BANK_AW, 10, address width of one bank (depth 2**BANK_AW).
NUM_BANKS, 2, bank count; power of two, at least 1.
RD_LATENCY, 1, cycles from ram_en to valid ram_rd_data; range 1..4.
OOR_DATA, 8'hFF, read data returned for out-of-range addresses.

Ports:
clock  in  1  single clock for bus and RAM port A
reset  in  1  synchronous, active-high
int_address  in  BUS_AW  bus address
int_wr_data  in  DATA_W  bus write data
int_write  in  1  write strobe, one cycle
int_read  in  1  read strobe, one cycle
int_req  in  1  bus request
int_gnt  out  1  bus grant
int_rd_data  out  DATA_W  read data, held until the next read completes
int_rd_valid  out  1  one-cycle pulse when int_rd_data updates
ram_addr  out  BANK_AW  shared bank address
ram_wr_data  out  DATA_W  shared write data
ram_we  out  NUM_BANKS  per-bank write enable, one-hot or zero
ram_en  out  NUM_BANKS  per-bank read enable, one-hot or zero
ram_rd_data  in  NUM_BANKS*DATA_W  bank k read data at bits [k*DATA_W +: DATA_W]
err_count  out  16  count of out-of-range accesses and dropped strobes

Behaviour:
- Reset:
  - All outputs are 0, except int_rd_data = 0.
  - FSM returns to IDLE and the read pipeline is flushed.
  - A read in flight when reset asserts never produces int_rd_valid.
- Grant:
  - int_gnt is registered.
  - It rises 1 cycle after int_req is sampled high and stays high while int_req is high.
  - It falls 1 cycle after int_req is sampled low.
- Strobe acceptance:
  - A strobe is accepted only in a cycle where int_gnt = 1.
  - Strobes without a grant are ignored and not counted.
- Address decode:
  - bank = int_address[BANK_AW +: log2(NUM_BANKS)]; bank = 0 when NUM_BANKS = 1.
  - An access is in range iff int_address < NUM_BANKS << BANK_AW.
  - Upper address bits above the bank field must be zero for an access to be in range.
- Write:
  - An accepted in-range write drives, on the next cycle only: ram_we[bank] = 1, ram_addr = int_address[BANK_AW-1:0], ram_wr_data = int_wr_data.
  - Back-to-back writes on consecutive cycles are supported, one per cycle.
- FSM states: IDLE, RD_WAIT.
- Read in IDLE:
  - An accepted read pulses ram_en[bank] for 1 cycle on the next cycle, with ram_addr set as for a write.
  - The FSM moves to RD_WAIT and latches the bank index.
- RD_WAIT:
  - RD_LATENCY cycles after the ram_en cycle, int_rd_data <= the selected ram_rd_data slice and int_rd_valid = 1 for 1 cycle.
  - The FSM returns to IDLE in that same cycle.
  - Total latency from read strobe to int_rd_valid is RD_LATENCY+1 cycles.
- Out-of-range read:
  - No ram_en is issued.
  - int_rd_data <= OOR_DATA with the same RD_LATENCY+1 timing.
  - err_count increments.
- Out-of-range write: no ram_we is issued; err_count increments.
- Simultaneous int_write and int_read:
  - The write is performed and the read is dropped.
  - err_count increments by 1.
- Strobe during RD_WAIT: the strobe is dropped and err_count increments by 1.
- int_req falling during RD_WAIT: int_gnt falls as normal, and the pending read still completes with int_rd_valid.
- err_count:
  - Increments by at most 1 per cycle.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Outputs are registered: no combinational path from bus inputs to the RAM outputs or to int_gnt.

Test Plan:
1. Reset check: hold reset 3 cycles, int_req = 1 -> int_gnt, ram_we, ram_en, int_rd_valid and err_count all 0. Then release reset -> int_gnt = 1 one cycle later.
2. Bank write decode (NUM_BANKS = 2, BANK_AW = 10): write 0x0005 <= 8'hA5 -> next cycle ram_we = 2'b01, ram_addr = 5, ram_wr_data = A5. Write 0x0405 <= 8'h5A -> ram_we = 2'b10, ram_addr = 5.
3. Read timing (RD_LATENCY = 2): bank1 model returns 8'h3C. Read 0x07FF -> ram_en = 2'b10 one cycle after the strobe, int_rd_valid 3 cycles after the strobe, int_rd_data = 3C, and 3C is held afterwards.
4. Out-of-range: read 0x0800 -> no ram_en, int_rd_data = FF after RD_LATENCY+1 cycles, err_count = 1. Then write 0xF000 -> no ram_we, err_count = 2.
5. Collisions: int_write and int_read asserted together at 0x0010 -> write performed, no ram_en, err_count +1. A read strobe issued during RD_WAIT -> dropped, err_count +1, and the first read still completes.
6. Robustness: reset asserted 1 cycle after a read strobe -> no int_rd_valid is ever produced. Force 70000 out-of-range writes -> err_count = FFFF and does not wrap.
